// File: rtl/display_pkg.sv
// Shared definitions for the count display driver.
// - conv_state_t : converter FSM encodings (IDLE / SHIFT / DONE)
// - SEG_BLANK    : all segments off (active-low)
// - AN_OFF       : all anodes off (active-low)
// - seg_code()   : BCD digit -> {g,f,e,d,c,b,a} active-low segment pattern
// - anode_for()  : scan digit index -> active-low anode pattern
// - bcd_adjust() : double-dabble "add 3 if >= 5" nibble correction
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [3:0] AN_OFF     = 4'b1111;
    localparam logic [1:0] LAST_DIGIT = 2'd2;
    localparam logic [2:0] LAST_SHIFT = 3'd7;

    function automatic logic [6:0] seg_code(input logic [3:0] digit);
        logic [6:0] code;
        case (digit)
            4'd0:    code = 7'b1000000;
            4'd1:    code = 7'b1111001;
            4'd2:    code = 7'b0100100;
            4'd3:    code = 7'b0110000;
            4'd4:    code = 7'b0011001;
            4'd5:    code = 7'b0010010;
            4'd6:    code = 7'b0000010;
            4'd7:    code = 7'b1111000;
            4'd8:    code = 7'b0000000;
            4'd9:    code = 7'b0010000;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

    // Index 0 = ones, 1 = tens, 2 = hundreds; an[3] is never driven low.
    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        logic [3:0] pattern;
        case (idx)
            2'd0:    pattern = 4'b1110;
            2'd1:    pattern = 4'b1101;
            2'd2:    pattern = 4'b1011;
            default: pattern = AN_OFF;
        endcase
        return pattern;
    endfunction

    function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/count_display_driver_if.sv
// Bundle between the counter core / board pins and the display driver.
// - count : 8-bit binary value to display (driven by the counter side)
// - an    : active-low digit anodes, an[3] unused (held 1)
// - seg   : active-low segments {g,f,e,d,c,b,a}
// - dp    : active-low decimal point, always off
// - busy  : high while a binary-to-BCD conversion is in flight
// Modports: master = counter/board side, slave = display driver.
interface count_display_driver_if;
    logic [7:0] count;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       busy;

    modport master (
        output count,
        input  an,
        input  seg,
        input  dp,
        input  busy
    );

    modport slave (
        input  count,
        output an,
        output seg,
        output dp,
        output busy
    );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary -> hundreds/tens/ones BCD.
// A conversion starts whenever bin differs from the last converted value and
// takes 1 latch cycle + 8 shift cycles + 1 commit cycle. The hund/tens/ones
// outputs are committed only at the end, so they never show partial results.
// Ports:
// - clk, rstn : clock, synchronous active-low reset
// - bin       : binary input, sampled only while idle
// - hund      : hundreds digit (0..2)
// - tens,ones : tens and ones digits (0..9)
// - busy      : high from the latch edge until the commit edge
module bin_to_bcd_seq
    import display_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] bin,
    output logic [1:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       busy
);

    conv_state_t state_reg, state_next;
    logic [7:0]  bin_sh_reg, bin_sh_next;
    logic [9:0]  bcd_acc_reg, bcd_acc_next;   // {hund[1:0], tens[3:0], ones[3:0]}
    logic [2:0]  shift_cnt_reg, shift_cnt_next;
    logic [7:0]  latched_reg, latched_next;
    logic [7:0]  last_val_reg, last_val_next;
    logic [9:0]  disp_reg, disp_next;

    // Nibble correction for ones (gi=0) and tens (gi=1). Hundreds never
    // reaches 5 for an 8-bit input, so it needs no correction.
    logic [7:0]  acc_adj;
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = bcd_adjust(bcd_acc_reg[gi*4 +: 4]);
        end
    endgenerate

    // One step of {hund,tens,ones,bin} << 1 after correction. Only hund[0]
    // is carried up; hund[1] would fall off the top and is always 0 here.
    logic [17:0] shifted;
    assign shifted = {bcd_acc_reg[8], acc_adj, bin_sh_reg, 1'b0};

    always_comb begin
        state_next     = state_reg;
        bin_sh_next    = bin_sh_reg;
        bcd_acc_next   = bcd_acc_reg;
        shift_cnt_next = shift_cnt_reg;
        latched_next   = latched_reg;
        last_val_next  = last_val_reg;
        disp_next      = disp_reg;
        busy           = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bin != last_val_reg) begin
                    latched_next   = bin;
                    bin_sh_next    = bin;
                    bcd_acc_next   = '0;
                    shift_cnt_next = '0;
                    state_next     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy           = 1'b1;
                bcd_acc_next   = shifted[17:8];
                bin_sh_next    = shifted[7:0];
                shift_cnt_next = shift_cnt_reg + 3'd1;
                if (shift_cnt_reg == LAST_SHIFT) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                busy          = 1'b1;
                disp_next     = bcd_acc_reg;
                last_val_next = latched_reg;
                state_next    = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg     <= ST_IDLE;
            bin_sh_reg    <= '0;
            bcd_acc_reg   <= '0;
            shift_cnt_reg <= '0;
            latched_reg   <= '0;
            last_val_reg  <= '0;
            disp_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            bin_sh_reg    <= bin_sh_next;
            bcd_acc_reg   <= bcd_acc_next;
            shift_cnt_reg <= shift_cnt_next;
            latched_reg   <= latched_next;
            last_val_reg  <= last_val_next;
            disp_reg      <= disp_next;
        end
    end

    assign hund = disp_reg[9:8];
    assign tens = disp_reg[7:4];
    assign ones = disp_reg[3:0];

endmodule

// File: rtl/count_display_driver.sv
// Three-digit multiplexed 7-segment readout of an 8-bit count.
// The converter sub-module produces stable BCD digits; this level scans
// ones -> tens -> hundreds, holding each digit REFRESH_DIV clocks, applies
// leading-zero blanking and registers the anode/segment outputs.
// Ports:
// - clk  : system clock
// - rstn : synchronous active-low reset
// - bus  : slave side of count_display_driver_if (count in; an, seg, dp, busy out)
// Parameter REFRESH_DIV: clocks per digit, must be >= 2.
module count_display_driver
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rstn,
    count_display_driver_if.slave  bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);

    logic [1:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       busy;

    bin_to_bcd_seq u_conv (
        .clk  (clk),
        .rstn (rstn),
        .bin  (bus.count),
        .hund (hund),
        .tens (tens),
        .ones (ones),
        .busy (busy)
    );

    logic [CW-1:0] refresh_reg, refresh_next;
    logic [1:0]    digit_idx_reg, digit_idx_next;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          refresh_wrap;

    assign refresh_wrap = (refresh_reg == REFRESH_LAST);

    always_comb begin
        refresh_next   = refresh_wrap ? '0 : refresh_reg + CW'(1);
        digit_idx_next = digit_idx_reg;
        if (refresh_wrap) begin
            digit_idx_next = (digit_idx_reg == LAST_DIGIT) ? 2'd0 : digit_idx_reg + 2'd1;
        end
    end

    // Output registers follow the current index, so a new digit appears
    // one edge after the index moves.
    always_comb begin
        an_next  = anode_for(digit_idx_reg);
        seg_next = SEG_BLANK;
        case (digit_idx_reg)
            2'd0: seg_next = seg_code(ones);
            2'd1: seg_next = (hund == 2'd0 && tens == 4'd0) ? SEG_BLANK : seg_code(tens);
            2'd2: seg_next = (hund == 2'd0) ? SEG_BLANK : seg_code({2'b00, hund});
            default: seg_next = SEG_BLANK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            refresh_reg   <= '0;
            digit_idx_reg <= 2'd0;
            an_reg        <= AN_OFF;
            seg_reg       <= SEG_BLANK;
        end else begin
            refresh_reg   <= refresh_next;
            digit_idx_reg <= digit_idx_next;
            an_reg        <= an_next;
            seg_reg       <= seg_next;
        end
    end

    assign bus.an   = an_reg;
    assign bus.seg  = seg_reg;
    assign bus.dp   = 1'b1;
    assign bus.busy = busy;

endmodule

// File: tb/tb_count_display_driver.sv
// Scoreboard bench for count_display_driver with REFRESH_DIV=4.
// Stimulus pushes every value that should be converted into exp_q; the
// monitor pops one entry each time busy falls and then checks every scanned
// digit against the decimal digits of the value currently on display.
module tb_count_display_driver;

    localparam int DIV = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    count_display_driver_if bus ();

    count_display_driver #(.REFRESH_DIV(DIV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic smp_rstn = 1'b0;
    logic started  = 1'b0;
    always @(posedge clk) begin
        smp_rstn <= rstn;
        started  <= 1'b1;
    end

    int  k         = -1;
    int  cur_val   = 0;
    int  pend_val  = 0;
    bit  have_pend = 0;
    bit  busy_prev = 0;
    int  busy_run  = 0;

    always @(negedge clk) begin
        int idx, h, t, o, ea, es;
        if (started) begin
            if (!smp_rstn) begin
                check("reset_an", 32'(bus.an), 32'hF);
                check("reset_seg", 32'(bus.seg), 32'h7F);
                check("reset_busy", 32'(bus.busy), 32'h0);
                k         = -1;
                cur_val   = 0;
                have_pend = 0;
                busy_prev = 0;
                busy_run  = 0;
                exp_q.delete();
            end else begin
                k++;
                if (have_pend) begin
                    cur_val   = pend_val;
                    have_pend = 0;
                end
                idx = (k / DIV) % 3;
                h = cur_val / 100;
                t = (cur_val / 10) % 10;
                o = cur_val % 10;
                case (idx)
                    0: begin ea = 4'b1110; es = seg_tab[o]; end
                    1: begin ea = 4'b1101; es = (h == 0 && t == 0) ? 7'h7F : seg_tab[t]; end
                    default: begin ea = 4'b1011; es = (h == 0) ? 7'h7F : seg_tab[h]; end
                endcase
                check("scan_an", 32'(bus.an), 32'(ea));
                check($sformatf("seg_val%0d_idx%0d", cur_val, idx), 32'(bus.seg), 32'(es));

                if (bus.busy === 1'b1) begin
                    busy_run++;
                end else if (busy_prev) begin
                    check("busy_len", 32'(busy_run), 32'd9);
                    busy_run = 0;
                    check("conv_expected", 32'(exp_q.size() > 0), 32'd1);
                    if (exp_q.size() > 0) begin
                        pend_val  = exp_q.pop_front();
                        have_pend = 1;
                    end
                end
                busy_prev = (bus.busy === 1'b1);
            end
            check("dp", 32'(bus.dp), 32'd1);
            check("an3", 32'(bus.an[3]), 32'd1);
        end
    end

    // ---------------- stimulus ----------------
    int model_last = 0;

    // The converter takes the value present when it is idle; a value held
    // while busy is picked up afterwards if it differs from the last one.
    task automatic drive(input int v);
        @(posedge clk);
        #1 bus.count = 8'(v);
        if (v != model_last) begin
            exp_q.push_back(v);
            model_last = v;
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        bus.count = 8'd0;
        rstn      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        settle(14);

        drive(255); settle(30);
        drive(7);   settle(30);
        drive(105); settle(30);

        // change while converting: 100 shown first, then 200
        drive(100); settle(4);
        drive(200); settle(40);

        // reset in the middle of a conversion of 200
        drive(50);  settle(30);
        drive(200); settle(4);
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        model_last = 0;
        @(negedge clk);
        #1;
        exp_q.push_back(200);
        model_last = 200;
        settle(30);

        for (int i = 0; i < 24; i++) begin
            int v, v2, d;
            v = $urandom_range(0, 255);
            drive(v);
            if ($urandom_range(0, 1) == 1) begin
                d  = $urandom_range(1, 9);
                v2 = $urandom_range(0, 255);
                repeat (d - 1) @(posedge clk);
                drive(v2);
            end
            settle(40);
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size() + int'(have_pend)), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
